// File: rtl/dff_reg_arbiter_if.sv
// Request/grant/acknowledge bundle between bus-side requesters and the
// shared flip-flop register arbiter. Requesters use the master modport,
// the arbiter uses the slave modport.
interface dff_reg_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       REQ;
   logic [2*NREQ-1:0]     OP;
   logic [NREQ*WIDTH-1:0] DIN;
   logic [NREQ-1:0]       GNT;
   logic                  ACK;
   logic [WIDTH-1:0]      Q;
   logic [WIDTH-1:0]      QF;
   logic                  BUSY;

   modport master (output REQ, OP, DIN, input GNT, ACK, Q, QF, BUSY);
   modport slave  (input REQ, OP, DIN, output GNT, ACK, Q, QF, BUSY);
endinterface

// File: rtl/dff_reg_arbiter.sv
// Arbiter and sequencer for a shared WIDTH-bit preset/clear register.
// Requesters are served one at a time through IDLE -> GRANT -> DONE; the
// granted operation (LOAD/PRESET/CLEAR/READ) is applied on the GRANT->DONE
// edge. Default build arbitrates round-robin from a rotating pointer;
// defining DFFARB_FIXED_PRIO_EN switches to fixed lowest-index priority
// and removes the pointer.
module dff_reg_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input logic              CLK,
   input logic              CLR,
   dff_reg_arbiter_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_PRESET = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_READ   = 2'b11
   } op_t;

   state_t            state;
   logic [IW-1:0]     winner;
   logic [NREQ-1:0]   gnt;
   logic              ack;
   logic              busy;
   logic [WIDTH-1:0]  q;
`ifndef DFFARB_FIXED_PRIO_EN
   logic [IW-1:0]     ptr;
`endif

   logic              pick_valid;
   logic [IW-1:0]     pick_idx;
   logic              win_req;
   op_t               win_op;
   logic [WIDTH-1:0]  win_din;

   // Choose the next winner from the live request vector.
   // Candidates are scanned from the farthest to the nearest priority
   // position so the highest-priority set bit is the last one written.
   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that
      // leaves it unassigned would infer a latch.
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
`ifdef DFFARB_FIXED_PRIO_EN
         if (bus.REQ[off]) begin
            pick_valid = 1'b1;
            pick_idx   = IW'(off);
         end
`else
         if (bus.REQ[(int'(ptr) + off) % NREQ]) begin
            pick_valid = 1'b1;
            pick_idx   = IW'((int'(ptr) + off) % NREQ);
         end
`endif
      end
   end

   // Fields of the latched winner, used on the GRANT -> DONE edge.
   always_comb begin
      win_req = bus.REQ[winner];
      win_op  = op_t'(bus.OP[2*winner +: 2]);
      win_din = bus.DIN[WIDTH*winner +: WIDTH];
   end

   // Handshake state machine, register bank and all registered outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the clock edge.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state  <= IDLE;
         winner <= '0;
         gnt    <= '0;
         ack    <= 1'b0;
         busy   <= 1'b0;
         q      <= '0;
`ifndef DFFARB_FIXED_PRIO_EN
         ptr    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ack <= 1'b0;
               if (pick_valid) begin
                  state  <= GRANT;
                  winner <= pick_idx;
                  gnt    <= NREQ'(1) << pick_idx;
                  busy   <= 1'b1;
               end
            end
            GRANT: begin
               gnt <= '0;
               if (win_req) begin
                  state <= DONE;
                  ack   <= 1'b1;
                  case (win_op)
                     OP_LOAD:   q <= win_din;
                     OP_PRESET: q <= '1;
                     OP_CLEAR:  q <= '0;
                     default:   q <= q;
                  endcase
`ifndef DFFARB_FIXED_PRIO_EN
                  ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif
               end else begin
                  // Requester withdrew: abort without touching Q or PTR.
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               ack   <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
               ack   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.GNT  = gnt;
   assign bus.ACK  = ack;
   assign bus.BUSY = busy;
   assign bus.Q    = q;
   assign bus.QF   = ~q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter. A transaction-level model keeps
// the expected register value and arbitration pointer; directed scenarios
// are followed by randomized request/opcode/data traffic.
module tb_dff_reg_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic CLK = 1'b0;
   logic CLR;

   always #5 CLK = ~CLK;

   dff_reg_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   dff_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] model_q;
   int               model_ptr;

   // Winner chosen by the arbitration rule for a request mask.
   function automatic int model_pick(input logic [NREQ-1:0] m);
`ifdef DFFARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++)
         if (m[i]) return i;
`else
      for (int off = 0; off < NREQ; off++)
         if (m[(model_ptr + off) % NREQ]) return (model_ptr + off) % NREQ;
`endif
      return -1;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      bus.REQ = '0;
      bus.OP  = '0;
      bus.DIN = '0;
      @(negedge CLK);
      CLR = 1'b0;
      @(negedge CLK);
      CLR = 1'b1;
      model_q   = '0;
      model_ptr = 0;
      tick();
   endtask

   // One complete transaction from IDLE, optionally aborted during GRANT.
   task automatic run_op(input logic [NREQ-1:0] mask, input logic [2*NREQ-1:0] ops,
                         input logic [NREQ*WIDTH-1:0] dins, input bit abort, input string tag);
      int              w;
      logic [NREQ-1:0] exp_gnt;
      bus.REQ = mask;
      bus.OP  = ops;
      bus.DIN = dins;
      w       = model_pick(mask);
      exp_gnt = NREQ'(1) << w;
      tick();
      checks++;
      if (bus.GNT !== exp_gnt) begin
         failures++;
         $display("FAIL %s grant: got %b expected %b", tag, bus.GNT, exp_gnt);
      end
      checks++;
      if (bus.BUSY !== 1'b1 || bus.ACK !== 1'b0) begin
         failures++;
         $display("FAIL %s grant-phase busy/ack: got %b/%b expected 1/0", tag, bus.BUSY, bus.ACK);
      end
      if (abort) begin
         bus.REQ = '0;
         tick();
         checks++;
         if (bus.ACK !== 1'b0 || bus.GNT !== '0 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s abort ack/gnt/busy: got %b/%b/%b expected 0/0/0",
                     tag, bus.ACK, bus.GNT, bus.BUSY);
         end
         checks++;
         if (bus.Q !== model_q) begin
            failures++;
            $display("FAIL %s abort q: got %h expected %h", tag, bus.Q, model_q);
         end
      end else begin
         case (ops[2*w +: 2])
            2'b00:   model_q = dins[WIDTH*w +: WIDTH];
            2'b01:   model_q = '1;
            2'b10:   model_q = '0;
            default: ;
         endcase
         model_ptr = (w + 1) % NREQ;
         tick();
         checks++;
         if (bus.Q !== model_q || bus.QF !== ~model_q) begin
            failures++;
            $display("FAIL %s q/qf: got %h/%h expected %h/%h", tag, bus.Q, bus.QF, model_q, ~model_q);
         end
         checks++;
         if (bus.ACK !== 1'b1 || bus.GNT !== '0 || bus.BUSY !== 1'b1) begin
            failures++;
            $display("FAIL %s done ack/gnt/busy: got %b/%b/%b expected 1/0/1",
                     tag, bus.ACK, bus.GNT, bus.BUSY);
         end
         bus.REQ = '0;
         tick();
         checks++;
         if (bus.ACK !== 1'b0 || bus.BUSY !== 1'b0 || bus.Q !== model_q) begin
            failures++;
            $display("FAIL %s idle ack/busy/q: got %b/%b/%h expected 0/0/%h",
                     tag, bus.ACK, bus.BUSY, bus.Q, model_q);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (bus.Q !== 8'h00 || bus.QF !== 8'hFF) begin
         failures++;
         $display("FAIL %s q/qf: got %h/%h expected 00/ff", tag, bus.Q, bus.QF);
      end
      checks++;
      if (bus.GNT !== 4'b0000 || bus.ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
         failures++;
         $display("FAIL %s gnt/ack/busy: got %b/%b/%b expected 0000/0/0",
                  tag, bus.GNT, bus.ACK, bus.BUSY);
      end
   endtask

   task automatic test_reset();
      CLR     = 1'b0;
      bus.REQ = '0;
      bus.OP  = '0;
      bus.DIN = '0;
      model_q   = '0;
      model_ptr = 0;
      #3;
      check_reset_outputs("reset_initial");
      @(negedge CLK);
      CLR = 1'b1;
      tick();
      // Make Q non-zero and move the pointer away from 0.
      run_op(4'b0100, 8'h00, 32'h00_77_00_00, 1'b0, "reset_preload");
      // Enter GRANT for requester 1, then reset mid-operation.
      bus.REQ = 4'b0010;
      tick();
      checks++;
      if (bus.GNT !== 4'b0010) begin
         failures++;
         $display("FAIL reset_grant: got %b expected 0010", bus.GNT);
      end
      #2;
      CLR = 1'b0;
      #1;
      check_reset_outputs("reset_midop");
      model_q   = '0;
      model_ptr = 0;
      bus.REQ   = '0;
      @(negedge CLK);
      CLR = 1'b1;
      tick();
      // PTR back at 0: requester 1 wins over 3.
      run_op(4'b1010, 8'h00, 32'h44_00_11_00, 1'b0, "reset_first_grant");
   endtask

   task automatic test_single_load();
      do_reset();
      run_op(4'b0100, 8'h00, 32'h00_A5_00_00, 1'b0, "single_load");
      checks++;
      if (bus.QF !== 8'h5A) begin
         failures++;
         $display("FAIL single_load qf: got %h expected 5a", bus.QF);
      end
   endtask

   task automatic test_round_robin();
      int              w;
      logic [NREQ-1:0] exp_gnt;
      do_reset();
      bus.REQ = 4'b1111;
      bus.OP  = 8'h00;
      bus.DIN = 32'h03_02_01_00;
      for (int g = 0; g < 5; g++) begin
         w       = model_pick(4'b1111);
         exp_gnt = NREQ'(1) << w;
         tick();
         checks++;
         if (bus.GNT !== exp_gnt) begin
            failures++;
            $display("FAIL round_robin grant %0d: got %b expected %b", g, bus.GNT, exp_gnt);
         end
         model_q   = WIDTH'(w);
         model_ptr = (w + 1) % NREQ;
         tick();
         checks++;
         if (bus.ACK !== 1'b1 || bus.Q !== model_q) begin
            failures++;
            $display("FAIL round_robin done %0d ack/q: got %b/%h expected 1/%h", g, bus.ACK, bus.Q, model_q);
         end
         tick();
         checks++;
         if (bus.ACK !== 1'b0 || bus.GNT !== '0) begin
            failures++;
            $display("FAIL round_robin idle %0d ack/gnt: got %b/%b expected 0/0000", g, bus.ACK, bus.GNT);
         end
      end
      bus.REQ = '0;
      tick();
   endtask

   task automatic test_opcodes();
      run_op(4'b0001, 8'h01, 32'h0, 1'b0, "op_preset");
      run_op(4'b0001, 8'h02, 32'h0, 1'b0, "op_clear");
      run_op(4'b0001, 8'h00, 32'h0000_003C, 1'b0, "op_load");
      run_op(4'b0001, 8'h03, 32'h0000_00C3, 1'b0, "op_read");
   endtask

   task automatic test_abort();
      run_op(4'b0001, 8'h00, 32'h0000_0066, 1'b0, "abort_setup");
      run_op(4'b0010, 8'h00, 32'h0000_9900, 1'b1, "abort");
      run_op(4'b1010, 8'h00, 32'h5500_AA00, 1'b0, "abort_followup");
   endtask

   task automatic test_back_to_back();
      int exp_cnt [NREQ];
      int got_cnt [NREQ];
      int acks;
      int w;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         exp_cnt[i] = 0;
         got_cnt[i] = 0;
      end
      for (int g = 0; g < 4; g++) begin
         w = model_pick(4'b1010);
         exp_cnt[w]++;
         model_ptr = (w + 1) % NREQ;
      end
      acks    = 0;
      bus.REQ = 4'b1010;
      bus.OP  = 8'hFF;
      for (int c = 0; c < 12; c++) begin
         tick();
         for (int i = 0; i < NREQ; i++)
            if (bus.GNT[i] === 1'b1) got_cnt[i]++;
         if (bus.ACK === 1'b1) acks++;
      end
      bus.REQ = '0;
      tick();
      for (int i = 0; i < NREQ; i++) begin
         checks++;
         if (got_cnt[i] !== exp_cnt[i]) begin
            failures++;
            $display("FAIL back_to_back grants[%0d]: got %0d expected %0d", i, got_cnt[i], exp_cnt[i]);
         end
      end
      checks++;
      if (acks !== 4 || bus.Q !== model_q) begin
         failures++;
         $display("FAIL back_to_back acks/q: got %0d/%h expected 4/%h", acks, bus.Q, model_q);
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0]       mask;
      logic [2*NREQ-1:0]     ops;
      logic [NREQ*WIDTH-1:0] dins;
      bit                    abort;
      for (int n = 0; n < 30; n++) begin
         mask  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         ops   = (2*NREQ)'($urandom);
         dins  = (NREQ*WIDTH)'($urandom);
         abort = ($urandom_range(0, 4) == 0);
         run_op(mask, ops, dins, abort, $sformatf("random_%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_round_robin();
      test_opcodes();
      test_abort();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Arbiter and sequencer for a shared WIDTH-bit register built from preset/clear D flip-flops. Up to NREQ requesters issue load, preset, clear or read operations over a request/grant/acknowledge handshake. The block serialises the operations, applies them to the register, and exposes the true (Q) and complement (QF) outputs. It sits between bus-side requesters and the flip-flop bank and is the only writer of that bank.

## Interface
- WIDTH, 8: register width in bits.
- NREQ, 4: number of requesters (≥2).

- CLK  input  1  clock; all state changes on the rising edge.
- CLR  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  per-requester request; held high until ACK is seen.
- OP  input  2*NREQ  per-requester opcode; requester i uses OP[2i+1:2i]. 00 LOAD, 01 PRESET, 10 CLEAR, 11 READ.
- DIN  input  NREQ*WIDTH  per-requester load data; requester i uses DIN[WIDTH*i+WIDTH-1:WIDTH*i].
- GNT  output  NREQ  one-hot grant; all zeros when nobody is granted.
- ACK  output  1  one-cycle completion pulse for the current grantee.
- Q  output  WIDTH  register contents.
- QF  output  WIDTH  always ~Q.
- BUSY  output  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no grant in progress.
  - GRANT: GNT is one-hot for the winner.
  - DONE: ACK is high; GNT is zero.
- IDLE → GRANT when any REQ bit is sampled high. The winner index is latched in the same cycle.
- Round-robin selection:
  - Search upward from pointer PTR: PTR, PTR+1, …, NREQ-1, then 0, …, PTR-1.
  - The first set REQ bit wins.
- GRANT → DONE if REQ[winner] is still high at the next edge. On that edge:
  - OP[winner] and DIN[winner] are sampled.
  - The operation is applied to Q.
  - ACK is set.
  - PTR is set to (winner+1) mod NREQ.
- GRANT → IDLE (abort) if REQ[winner] is low at that edge. On abort there is no ACK, Q is unchanged and PTR is unchanged.
- DONE → IDLE unconditionally.
- Operations:
  - LOAD: Q ← DIN[winner].
  - PRESET: Q ← all ones.
  - CLEAR: Q ← all zeros.
  - READ: Q unchanged; ACK is still issued.
- Q changes only on the GRANT → DONE edge or on reset.
- Requester rule: drop REQ by the edge that ends DONE. A REQ still high in the following IDLE cycle is treated as a new request.
- Async reset (CLR low), including mid-operation:
  - Q = 0, QF = all ones, GNT = 0, ACK = 0, BUSY = 0.
  - State = IDLE, PTR = 0.
  - Any in-flight operation is discarded.
- Release of CLR is not synchronised by this block; the reset source guarantees a clean deassertion.

## Timing
- REQ sampled at edge k in IDLE: GNT valid after edge k.
- Edge k+1: Q/QF updated and ACK high for exactly one cycle (k+1 to k+2).
- Edge k+2: back in IDLE. The earliest next grant is after edge k+3.
- Throughput: one operation per 3 cycles under continuous demand.
- GNT, ACK, BUSY, Q and QF are all registered outputs; there are no combinational paths from inputs to outputs.
- OP/DIN only need to be stable at the GRANT → DONE edge.

## Configuration
- DFFARB_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest set REQ index always wins.
  - PTR is not implemented.
  - Starvation is possible and is accepted.
- Not defined: round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
Defaults for all scenarios: WIDTH=8, NREQ=4.
- Reset: assert CLR low while in GRANT for requester 1 → immediately Q=8'h00, QF=8'hFF, GNT=4'b0000, ACK=0, BUSY=0. After release, the first request is granted with PTR=0.
- Single load: REQ=4'b0100, OP[5:4]=00, DIN[23:16]=8'hA5 → GNT=4'b0100 after edge 1; after edge 2 Q=8'hA5, QF=8'h5A, ACK=1 for one cycle; BUSY low after edge 3.
- Round-robin: REQ=4'b1111 held, every requester LOADs its own index value → grant order 0,1,2,3,0. Q sequence is 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, with one ACK every 3 cycles.
- Opcodes, applied in order on requester 0:
  - PRESET → Q=8'hFF.
  - CLEAR → Q=8'h00.
  - LOAD 8'h3C → Q=8'h3C.
  - READ → Q stays 8'h3C and ACK pulses.
- Abort: REQ=4'b0010, then drop REQ[1] during GRANT → no ACK, Q unchanged, PTR unchanged. A following REQ=4'b1010 is granted to 1.
- DFFARB_FIXED_PRIO_EN build: REQ=4'b1010 held for 12 cycles → 4 grants, all to requester 1; requester 3 is never granted.
